rvfi_retire_monitor: RTL and testbench

- Per-channel retirement monitor, directly downstream of the per-channel RVFI field slicer; consumes one channel's decoded fields.
- Tracks the retirement stream across cycles and raises sticky error flags:
  - order gaps
  - PC discontinuity
  - retirement after halt
  - x0 writes
  - illegal memory masks
- Feeds the formal check harness: flags drive asserts; the `first_seen` and `halted` status drives covers.

---
 rtl/rvfi_retire_monitor.sv | 118 +++++++++++
 tb/tb_rvfi_retire_monitor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rvfi_retire_monitor.sv
// rvfi_retire_monitor: sticky order/PC/halt/x0/mask checks on one RVFI channel.
// Optional retirement/trap counters when RISCV_FORMAL_RETIRE_STATS_EN is defined.
module rvfi_retire_monitor #(
  parameter int          XLEN        = 32,
  parameter logic [63:0] ORDER_START = 64'd0,
  parameter bit          CHECK_PC    = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic [63:0]       order,
  input  logic              trap,
  input  logic              halt,
  input  logic              intr,
  input  logic [4:0]        rd_addr,
  input  logic [XLEN-1:0]   rd_wdata,
  input  logic [XLEN-1:0]   pc_rdata,
  input  logic [XLEN-1:0]   pc_wdata,
  input  logic [XLEN/8-1:0] mem_rmask,
  input  logic [XLEN/8-1:0] mem_wmask,
  output logic              first_seen,
  output logic              halted,
  output logic              err_order,
  output logic              err_pc,
  output logic              err_halt,
  output logic              err_x0,
  output logic              err_mask,
  output logic              err_any
`ifdef RISCV_FORMAL_RETIRE_STATS_EN
  ,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       trap_cnt
`endif
);
  localparam int MW = XLEN / 8;
  typedef enum logic [1:0] {WAIT_FIRST, RUN, HALTED} state_t;
  state_t state_q, state_d;
  logic [63:0] exp_order_q, exp_order_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic first_seen_q, first_seen_d, halted_q, halted_d;
  logic err_order_q, err_order_d, err_pc_q, err_pc_d, err_halt_q, err_halt_d;
  logic err_x0_q, err_x0_d, err_mask_q, err_mask_d, err_any_q, err_any_d;
  logic live, bad_mask;
  // Filling below the lowest set bit leaves 2^n-1 exactly when the mask is one run.
  function automatic logic contig(input logic [MW-1:0] m);
    logic [MW-1:0] f;
    f = m | (m - MW'(1));
    return (f & (f + MW'(1))) == '0;
  endfunction
  always_comb begin
    live         = valid && (state_q != HALTED);
    bad_mask     = (trap && ((mem_rmask | mem_wmask) != '0)) || !contig(mem_rmask) || !contig(mem_wmask);
    state_d      = live ? (halt ? HALTED : RUN) : state_q;
    exp_order_d  = live ? order + 64'd1 : exp_order_q;
    last_pc_d    = live ? pc_wdata : last_pc_q;
    first_seen_d = first_seen_q | live;
    halted_d     = halted_q | (state_d == HALTED);
    err_order_d  = err_order_q | (live && (order != exp_order_q));
    err_pc_d     = err_pc_q | (CHECK_PC && live && (state_q == RUN) && !intr && (pc_rdata != last_pc_q));
    err_halt_d   = err_halt_q | (valid && (state_q == HALTED));
    err_x0_d     = err_x0_q | (live && (rd_addr == 5'd0) && (rd_wdata != '0));
    err_mask_d   = err_mask_q | (valid && bad_mask);
    err_any_d    = err_order_q | err_pc_q | err_halt_q | err_x0_q | err_mask_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= WAIT_FIRST;
      exp_order_q  <= ORDER_START;
      last_pc_q    <= '0;
      first_seen_q <= 1'b0;
      halted_q     <= 1'b0;
      err_order_q  <= 1'b0;
      err_pc_q     <= 1'b0;
      err_halt_q   <= 1'b0;
      err_x0_q     <= 1'b0;
      err_mask_q   <= 1'b0;
      err_any_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_order_q  <= exp_order_d;
      last_pc_q    <= last_pc_d;
      first_seen_q <= first_seen_d;
      halted_q     <= halted_d;
      err_order_q  <= err_order_d;
      err_pc_q     <= err_pc_d;
      err_halt_q   <= err_halt_d;
      err_x0_q     <= err_x0_d;
      err_mask_q   <= err_mask_d;
      err_any_q    <= err_any_d;
    end
  end
  assign first_seen = first_seen_q;
  assign halted     = halted_q;
  assign err_order  = err_order_q;
  assign err_pc     = err_pc_q;
  assign err_halt   = err_halt_q;
  assign err_x0     = err_x0_q;
  assign err_mask   = err_mask_q;
  assign err_any    = err_any_q;
`ifdef RISCV_FORMAL_RETIRE_STATS_EN
  logic [31:0] retired_cnt_q, retired_cnt_d, trap_cnt_q, trap_cnt_d;
  always_comb begin
    retired_cnt_d = (live && !(&retired_cnt_q)) ? retired_cnt_q + 32'd1 : retired_cnt_q;
    trap_cnt_d    = (live && trap && !(&trap_cnt_q)) ? trap_cnt_q + 32'd1 : trap_cnt_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      retired_cnt_q <= '0;
      trap_cnt_q    <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
      trap_cnt_q    <= trap_cnt_d;
    end
  end
  assign retired_cnt = retired_cnt_q;
  assign trap_cnt    = trap_cnt_q;
`endif
endmodule

// File: tb/tb_rvfi_retire_monitor.sv
// tb_rvfi_retire_monitor: directed scenarios plus randomized run against a retirement-stream model.
module tb_rvfi_retire_monitor;
  localparam logic [63:0] OS = 64'hFFFF_FFFF_FFFF_FFFD;
  logic clk = 1'b0;
  logic reset, valid, trap, halt, intr;
  logic [63:0] order;
  logic [4:0] rd_addr;
  logic [31:0] rd_wdata, pc_rdata, pc_wdata;
  logic [3:0] mem_rmask, mem_wmask;
  logic first_seen, halted, err_order, err_pc, err_halt, err_x0, err_mask, err_any;
  logic [7:0] obs;
  int vecs = 0;
  int errs = 0;
  bit m_seen, m_halted, e_order, e_pc, e_halt, e_x0, e_mask, e_any;
  logic [63:0] m_next_order;
  logic [31:0] m_pc;
  longint m_ret, m_trap;
`ifdef RISCV_FORMAL_RETIRE_STATS_EN
  logic [31:0] retired_cnt, trap_cnt;
`endif
  always #5 clk = ~clk;
  rvfi_retire_monitor #(.XLEN(32), .ORDER_START(OS), .CHECK_PC(1'b1)) dut (
    .clock(clk), .reset(reset), .valid(valid), .order(order), .trap(trap), .halt(halt), .intr(intr),
    .rd_addr(rd_addr), .rd_wdata(rd_wdata), .pc_rdata(pc_rdata), .pc_wdata(pc_wdata),
    .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .first_seen(first_seen), .halted(halted),
    .err_order(err_order), .err_pc(err_pc), .err_halt(err_halt), .err_x0(err_x0),
    .err_mask(err_mask), .err_any(err_any)
`ifdef RISCV_FORMAL_RETIRE_STATS_EN
    , .retired_cnt(retired_cnt), .trap_cnt(trap_cnt)
`endif
  );
  assign obs = {first_seen, halted, err_order, err_pc, err_halt, err_x0, err_mask, err_any};
  function automatic bit one_run(input logic [3:0] m);
    int runs = 0;
    bit p = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m[i] && !p) runs++;
      p = m[i];
    end
    return runs <= 1;
  endfunction
  task automatic go(input bit r, input bit v, input logic [63:0] o, input logic [31:0] pr,
                    input logic [31:0] pw, input bit tr = 0, input bit hl = 0, input bit it = 0,
                    input logic [4:0] ra = 5'd1, input logic [31:0] rw = 0,
                    input logic [3:0] rm = 0, input logic [3:0] wm = 0);
    bit any;
    reset = r; valid = v; order = o; pc_rdata = pr; pc_wdata = pw; trap = tr; halt = hl;
    intr = it; rd_addr = ra; rd_wdata = rw; mem_rmask = rm; mem_wmask = wm;
    @(posedge clk); #1;
    if (r) begin
      {m_seen, m_halted, e_order, e_pc, e_halt, e_x0, e_mask, e_any} = '0;
      m_next_order = OS; m_pc = 0; m_ret = 0; m_trap = 0;
    end else begin
      any = e_order | e_pc | e_halt | e_x0 | e_mask;
      if (v) begin
        if (m_halted) e_halt = 1;
        else begin
          if (o != m_next_order) e_order = 1;
          if (m_seen && !it && pr != m_pc) e_pc = 1;
          if (ra == 0 && rw != 0) e_x0 = 1;
          m_next_order = o + 1;
          m_pc = pw;
          m_seen = 1;
          if (hl) m_halted = 1;
          if (m_ret < 64'hFFFF_FFFF) m_ret++;
          if (tr && m_trap < 64'hFFFF_FFFF) m_trap++;
        end
        if ((tr && (rm | wm) != 0) || !one_run(rm) || !one_run(wm)) e_mask = 1;
      end
      e_any = any;
    end
  endtask
  task automatic test_reset;
    go(1, 0, 0, 0, 0);
    vecs++; if (obs !== 8'h00) begin errs++; $display("FAIL reset_idle obs=%h exp=00", obs); end
    go(1, 1, 64'h55, 32'h10, 32'h20, 1, 1, 0, 5'd0, 32'h5, 4'h5, 4'h9);
    vecs++; if (obs !== 8'h00) begin errs++; $display("FAIL reset_priority obs=%h exp=00", obs); end
  endtask
  task automatic test_sequential;
    go(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      go(0, 1, OS + 64'(i), 32'(4 * i), 32'(4 * i + 4));
      vecs++; if (obs !== 8'h80) begin errs++; $display("FAIL seq%0d obs=%h exp=80", i, obs); end
    end
`ifdef RISCV_FORMAL_RETIRE_STATS_EN
    vecs++; if (retired_cnt !== 32'd4) begin errs++; $display("FAIL seq_cnt got=%0d exp=4", retired_cnt); end
`endif
  endtask
  task automatic test_order_gap;
    go(1, 0, 0, 0, 0);
    go(0, 1, OS, 0, 4);
    go(0, 1, OS + 1, 4, 8);
    go(0, 1, OS + 3, 8, 12);
    vecs++; if (obs !== 8'hA0) begin errs++; $display("FAIL gap_set obs=%h exp=a0", obs); end
    go(0, 1, OS + 4, 12, 16);
    vecs++; if (obs !== 8'hA1) begin errs++; $display("FAIL gap_any obs=%h exp=a1", obs); end
    go(0, 0, 0, 0, 0);
    vecs++; if (obs !== 8'hA1) begin errs++; $display("FAIL gap_sticky obs=%h exp=a1", obs); end
  endtask
  task automatic test_pc;
    go(1, 0, 0, 0, 0);
    go(0, 1, OS, 0, 32'h100);
    go(0, 1, OS + 1, 32'h200, 32'h204);
    vecs++; if (obs !== 8'h90) begin errs++; $display("FAIL pc_jump obs=%h exp=90", obs); end
    go(1, 0, 0, 0, 0);
    go(0, 1, OS, 0, 32'h100);
    go(0, 1, OS + 1, 32'h200, 32'h204, 0, 0, 1);
    vecs++; if (obs !== 8'h80) begin errs++; $display("FAIL pc_intr obs=%h exp=80", obs); end
    go(0, 1, OS + 2, 32'h204, 32'h208);
    vecs++; if (obs !== 8'h80) begin errs++; $display("FAIL pc_after_intr obs=%h exp=80", obs); end
  endtask
  task automatic test_halt;
    go(1, 0, 0, 0, 0);
    go(0, 1, OS, 0, 4, 0, 1);
    vecs++; if (obs !== 8'hC0) begin errs++; $display("FAIL halt_set obs=%h exp=c0", obs); end
    go(0, 1, OS + 9, 32'h40, 32'h44, 0, 0, 0, 5'd0, 32'h7);
    vecs++; if (obs !== 8'hC8) begin errs++; $display("FAIL halt_retire obs=%h exp=c8", obs); end
    go(0, 0, 0, 0, 0);
    vecs++; if (obs !== 8'hC9) begin errs++; $display("FAIL halt_any obs=%h exp=c9", obs); end
  endtask
  task automatic test_x0_mask;
    go(1, 0, 0, 0, 0);
    go(0, 1, OS, 0, 4, 0, 0, 0, 5'd0, 32'h5);
    vecs++; if (obs !== 8'h84) begin errs++; $display("FAIL x0 obs=%h exp=84", obs); end
    go(1, 0, 0, 0, 0);
    go(0, 1, OS, 0, 4, 0, 0, 0, 5'd1, 0, 4'h0, 4'h5);
    vecs++; if (obs !== 8'h82) begin errs++; $display("FAIL wmask_gap obs=%h exp=82", obs); end
    go(1, 0, 0, 0, 0);
    go(0, 1, OS, 0, 4, 1, 0, 0, 5'd1, 0, 4'h3, 4'h0);
    vecs++; if (obs !== 8'h82) begin errs++; $display("FAIL trap_mask obs=%h exp=82", obs); end
    go(1, 0, 0, 0, 0);
    go(0, 1, OS, 0, 4, 0, 0, 0, 5'd0, 0, 4'h0, 4'hC);
    vecs++; if (obs !== 8'h80) begin errs++; $display("FAIL wmask_ok obs=%h exp=80", obs); end
    go(1, 0, 0, 0, 0);
    go(0, 0, 64'h9, 32'h8, 32'h0, 1, 1, 0, 5'd0, 32'h5, 4'h5, 4'hA);
    vecs++; if (obs !== 8'h00) begin errs++; $display("FAIL invalid_ignored obs=%h exp=00", obs); end
  endtask
  task automatic test_midstream_reset;
    go(1, 0, 0, 0, 0);
    go(0, 1, OS + 7, 0, 4, 0, 0, 0, 5'd0, 32'h5);
    go(0, 0, 0, 0, 0);
    vecs++; if (obs !== 8'hA5) begin errs++; $display("FAIL mid_pre obs=%h exp=a5", obs); end
    go(1, 0, 0, 0, 0);
    vecs++; if (obs !== 8'h00) begin errs++; $display("FAIL mid_clear obs=%h exp=00", obs); end
    go(0, 1, OS, 32'h80, 32'h84);
    vecs++; if (obs !== 8'h80) begin errs++; $display("FAIL mid_restart obs=%h exp=80", obs); end
  endtask
  task automatic test_random;
    logic [3:0] masks [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h8, 4'hC, 4'hF, 4'h5, 4'h9, 4'hA, 4'hB, 4'hD};
    logic [63:0] o;
    logic [31:0] pr, pw, rw;
    go(1, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      o  = ($urandom_range(0, 11) == 0) ? {$urandom, $urandom} : m_next_order;
      pr = ($urandom_range(0, 9) == 0) ? ($urandom & ~32'h3) : m_pc;
      pw = ($urandom_range(0, 5) == 0) ? ($urandom & ~32'h3) : pr + 4;
      rw = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
      go($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, o, pr, pw,
         $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0,
         ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), rw,
         ($urandom_range(0, 2) == 0) ? masks[$urandom_range(0, 13)] : 4'h0,
         ($urandom_range(0, 2) == 0) ? masks[$urandom_range(0, 13)] : 4'h0);
      vecs++;
      if (obs !== {m_seen, m_halted, e_order, e_pc, e_halt, e_x0, e_mask, e_any}) begin
        errs++;
        $display("FAIL rand%0d obs=%h exp=%h", n, obs, {m_seen, m_halted, e_order, e_pc, e_halt, e_x0, e_mask, e_any});
      end
`ifdef RISCV_FORMAL_RETIRE_STATS_EN
      vecs++;
      if (retired_cnt !== 32'(m_ret) || trap_cnt !== 32'(m_trap)) begin
        errs++;
        $display("FAIL rand_cnt%0d got=%0d/%0d exp=%0d/%0d", n, retired_cnt, trap_cnt, m_ret, m_trap);
      end
`endif
    end
  endtask
  initial begin
    test_reset();
    test_sequential();
    test_order_gap();
    test_pc();
    test_halt();
    test_x0_mask();
    test_midstream_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
